// File: rtl/wave_bank_ctrl_if.sv
// Host/datapath signal bundle for the oscillator parameter-bank controller.
// slave = controller side, master = host and datapath side.
interface wave_bank_ctrl_if #(
   parameter int NCH = 64
);
   localparam int CW = $clog2(NCH);

   logic              run;
   logic              wr_valid;
   logic              wr_ready;
   logic [CW-1:0]     wr_chan;
   logic [1:0]        wr_field;
   logic [15:0]       wr_data;
   logic              commit;
   logic              commit_pending;
   logic              commit_done;
   logic              wr_err;
   logic [NCH*16-1:0] amps;
   logic [NCH*16-1:0] offsets;
   logic [NCH*16-1:0] phasewords;
   logic              dp_active;
   logic [15:0]       dp_result;
   logic              dp_valid;
   logic [15:0]       sample_out;
   logic              sample_valid;

   modport slave (
      input  run, wr_valid, wr_chan, wr_field, wr_data, commit, dp_result, dp_valid,
      output wr_ready, commit_pending, commit_done, wr_err, amps, offsets, phasewords,
             dp_active, sample_out, sample_valid
   );

   modport master (
      output run, wr_valid, wr_chan, wr_field, wr_data, commit, dp_result, dp_valid,
      input  wr_ready, commit_pending, commit_done, wr_err, amps, offsets, phasewords,
             dp_active, sample_out, sample_valid
   );
endinterface

// File: rtl/wave_bank_ctrl.sv
// Parameter-bank controller: word-serial shadow writes, atomic commit to the active
// bank on a sample boundary, sample strobe generation and result capture.
module wave_bank_ctrl #(
   parameter int NCH        = 64,
   parameter int SAMPLE_DIV = 16
) (
   input logic             clk,
   input logic             reset,
   wave_bank_ctrl_if.slave ctrl_if
);
   localparam int BW    = NCH * 16;
   localparam int CW    = $clog2(NCH);
   localparam int CNT_W = $clog2(SAMPLE_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PENDING = 2'd2,
      ST_APPLY   = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BW-1:0]    sh_amp_q, sh_amp_d, sh_off_q, sh_off_d, sh_ph_q, sh_ph_d;
   logic [BW-1:0]    act_amp_q, act_amp_d, act_off_q, act_off_d, act_ph_q, act_ph_d;
   logic             wr_err_q, wr_err_d;
   logic             wr_ready_q, commit_pending_q, commit_done_q, dp_active_q;
   logic [15:0]      sample_out_q;
   logic             sample_valid_q;
   logic             tick_s, wr_accept_s, apply_now_s;
   logic [CW+3:0]    wr_base_s;

   assign tick_s      = ctrl_if.run & (cnt_q == CNT_MAX);
   assign wr_accept_s = ctrl_if.wr_valid & wr_ready_q;
   assign wr_base_s   = {ctrl_if.wr_chan, 4'b0000};
   // A tick-entered APPLY copies at its entry edge so the strobe sees the new set;
   // repeating the copy at the APPLY edge is harmless because writes are held off.
   assign apply_now_s = (state_q == ST_APPLY) | ((state_q == ST_PENDING) & tick_s);

   // Sample tick counter next state
   always_comb begin
      cnt_d = cnt_q;
      if (!ctrl_if.run) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Commit sequencing FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (ctrl_if.commit)   state_d = ST_APPLY;
            else if (ctrl_if.run) state_d = ST_RUN;
            else                  state_d = ST_IDLE;
         end
         ST_RUN: begin
            if (ctrl_if.commit)    state_d = ST_PENDING;
            else if (!ctrl_if.run) state_d = ST_IDLE;
            else                   state_d = ST_RUN;
         end
         ST_PENDING: begin
            if (tick_s || !ctrl_if.run) state_d = ST_APPLY;
            else                        state_d = ST_PENDING;
         end
         ST_APPLY: begin
            if (ctrl_if.run) state_d = ST_RUN;
            else             state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Shadow bank write port and reserved-field error flag
   always_comb begin
      sh_amp_d = sh_amp_q;
      sh_off_d = sh_off_q;
      sh_ph_d  = sh_ph_q;
      wr_err_d = wr_err_q;
      if (wr_accept_s) begin
         case (ctrl_if.wr_field)
            2'd0:    sh_amp_d[wr_base_s +: 16] = ctrl_if.wr_data;
            2'd1:    sh_off_d[wr_base_s +: 16] = ctrl_if.wr_data;
            2'd2:    sh_ph_d[wr_base_s +: 16]  = ctrl_if.wr_data;
            default: wr_err_d = 1'b1;
         endcase
      end else begin
         wr_err_d = wr_err_q;
      end
   end

   // Active bank copy on apply
   always_comb begin
      act_amp_d = act_amp_q;
      act_off_d = act_off_q;
      act_ph_d  = act_ph_q;
      if (apply_now_s) begin
         act_amp_d = sh_amp_d;
         act_off_d = sh_off_d;
         act_ph_d  = sh_ph_d;
      end else begin
         act_amp_d = act_amp_q;
         act_off_d = act_off_q;
         act_ph_d  = act_ph_q;
      end
   end

   // State, counter and bank registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         sh_amp_q  <= '0;
         sh_off_q  <= '0;
         sh_ph_q   <= '0;
         act_amp_q <= '0;
         act_off_q <= '0;
         act_ph_q  <= '0;
         wr_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sh_amp_q  <= sh_amp_d;
         sh_off_q  <= sh_off_d;
         sh_ph_q   <= sh_ph_d;
         act_amp_q <= act_amp_d;
         act_off_q <= act_off_d;
         act_ph_q  <= act_ph_d;
         wr_err_q  <= wr_err_d;
      end
   end

   // Registered handshake, status and strobe outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ready_q       <= 1'b0;
         commit_pending_q <= 1'b0;
         commit_done_q    <= 1'b0;
         dp_active_q      <= 1'b0;
      end else begin
         wr_ready_q       <= (state_d != ST_APPLY);
         commit_pending_q <= (state_d == ST_PENDING) || (state_d == ST_APPLY);
         commit_done_q    <= (state_q == ST_APPLY);
         dp_active_q      <= tick_s;
      end
   end

   // Datapath result capture, independent of the commit state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sample_out_q   <= 16'h0000;
         sample_valid_q <= 1'b0;
      end else begin
         if (ctrl_if.dp_valid) begin
            sample_out_q <= ctrl_if.dp_result;
         end else begin
            sample_out_q <= sample_out_q;
         end
         sample_valid_q <= ctrl_if.dp_valid;
      end
   end

   assign ctrl_if.wr_ready       = wr_ready_q;
   assign ctrl_if.commit_pending = commit_pending_q;
   assign ctrl_if.commit_done    = commit_done_q;
   assign ctrl_if.wr_err         = wr_err_q;
   assign ctrl_if.amps           = act_amp_q;
   assign ctrl_if.offsets        = act_off_q;
   assign ctrl_if.phasewords     = act_ph_q;
   assign ctrl_if.dp_active      = dp_active_q;
   assign ctrl_if.sample_out     = sample_out_q;
   assign ctrl_if.sample_valid   = sample_valid_q;
endmodule

// File: tb/tb_wave_bank_ctrl.sv
// Directed-plus-random bench for wave_bank_ctrl; banks are tracked as plain arrays
// and active values follow the commit timing rules of the block.
module tb_wave_bank_ctrl;
   localparam int NCH  = 64;
   localparam int SDIV = 4;

   logic clk = 1'b0;
   logic reset;

   wave_bank_ctrl_if #(.NCH(NCH)) bus ();

   wave_bank_ctrl #(.NCH(NCH), .SAMPLE_DIV(SDIV)) dut (
      .clk     (clk),
      .reset   (reset),
      .ctrl_if (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [15:0] m_sh  [3][NCH];
   logic [15:0] m_act [3][NCH];
   logic        m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int f = 0; f < 3; f++) begin
         for (int c = 0; c < NCH; c++) begin
            m_sh[f][c]  = 16'h0000;
            m_act[f][c] = 16'h0000;
         end
      end
      m_err = 1'b0;
   endtask

   task automatic check_banks(input string tag);
      for (int c = 0; c < NCH; c++) begin
         check({tag, "_amp"}, {16'h0000, bus.amps[c*16 +: 16]},       {16'h0000, m_act[0][c]});
         check({tag, "_off"}, {16'h0000, bus.offsets[c*16 +: 16]},    {16'h0000, m_act[1][c]});
         check({tag, "_ph"},  {16'h0000, bus.phasewords[c*16 +: 16]}, {16'h0000, m_act[2][c]});
      end
   endtask

   task automatic do_write(input int ch, input int fld, input logic [15:0] d);
      int n;
      n = 0;
      bus.wr_valid = 1'b1;
      bus.wr_chan  = 6'(ch);
      bus.wr_field = 2'(fld);
      bus.wr_data  = d;
      while (bus.wr_ready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check("wr_accept_wait", 32'(n < 20), 32'd1);
      step();
      bus.wr_valid = 1'b0;
      if (fld < 3) m_sh[fld][ch] = d;
      else         m_err = 1'b1;
   endtask

   task automatic commit_idle(input string tag);
      bus.commit = 1'b1;
      step();
      bus.commit = 1'b0;
      check({tag, "_pend"}, 32'(bus.commit_pending), 32'd1);
      check({tag, "_done0"}, 32'(bus.commit_done), 32'd0);
      check_banks({tag, "_pre"});
      step();
      m_act = m_sh;
      check({tag, "_done1"}, 32'(bus.commit_done), 32'd1);
      check({tag, "_pend0"}, 32'(bus.commit_pending), 32'd0);
      check_banks({tag, "_post"});
      step();
      check({tag, "_done_once"}, 32'(bus.commit_done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n_done;
      logic [15:0] xdat;
      logic [15:0] rdat;

      reset = 1'b0;
      bus.run = 1'b0; bus.wr_valid = 1'b0; bus.wr_chan = 6'd0; bus.wr_field = 2'd0;
      bus.wr_data = 16'h0000; bus.commit = 1'b0; bus.dp_result = 16'h0000; bus.dp_valid = 1'b0;
      model_clear();
      #1;
      check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
      check("rst_pending", 32'(bus.commit_pending), 32'd0);
      check("rst_done", 32'(bus.commit_done), 32'd0);
      check("rst_wr_err", 32'(bus.wr_err), 32'd0);
      check("rst_dp_active", 32'(bus.dp_active), 32'd0);
      check("rst_sample", {16'h0000, bus.sample_out}, 32'd0);
      check("rst_sample_valid", 32'(bus.sample_valid), 32'd0);
      check_banks("rst_bank");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      step();
      check("idle_wr_ready", 32'(bus.wr_ready), 32'd1);
      for (int i = 0; i < 100; i++) begin
         step();
         check("idle_no_strobe", 32'(bus.dp_active), 32'd0);
      end

      // strobe cadence, stop, restart from zero
      bus.run = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         step();
         check("strobe", 32'(bus.dp_active), 32'((k % SDIV) == 0));
      end
      bus.run = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         check("strobe_stopped", 32'(bus.dp_active), 32'd0);
      end
      bus.run = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         check("strobe_restart", 32'(bus.dp_active), 32'((k % SDIV) == 0));
      end
      bus.run = 1'b0;
      step();

      // idle writes never reach the active bank before a commit
      for (int i = 0; i < 12; i++) begin
         do_write($urandom_range(0, NCH - 1), $urandom_range(0, 2), 16'($urandom));
      end
      do_write(5, 0, 16'h8001);
      do_write(63, 2, 16'h1234);
      check_banks("idle_shadow_only");
      commit_idle("commit1");
      check("amp_ch5", {16'h0000, bus.amps[95:80]}, 32'h0000_8001);
      check("ph_ch63", {16'h0000, bus.phasewords[1023:1008]}, 32'h0000_1234);

      // write held off during APPLY, then accepted
      xdat = 16'($urandom) | 16'h0001;
      bus.commit = 1'b1;
      step();
      bus.commit = 1'b0;
      bus.wr_valid = 1'b1; bus.wr_chan = 6'd7; bus.wr_field = 2'd0; bus.wr_data = xdat;
      check("apply_holdoff", 32'(bus.wr_ready), 32'd0);
      step();
      m_act = m_sh;
      check("apply_ready_back", 32'(bus.wr_ready), 32'd1);
      check("apply_done", 32'(bus.commit_done), 32'd1);
      check_banks("apply_copy");
      step();
      bus.wr_valid = 1'b0;
      m_sh[0][7] = xdat;
      check_banks("late_write_shadow");
      do_write(9, 3, 16'($urandom));
      check("wr_err_set", 32'(bus.wr_err), 32'(m_err));
      for (int i = 0; i < 6; i++) begin
         do_write($urandom_range(0, NCH - 1), $urandom_range(0, 2), 16'($urandom));
      end
      commit_idle("commit2");
      check("wr_err_sticky", 32'(bus.wr_err), 32'd1);

      // running commit waits for the next tick
      bus.run = 1'b1;
      step();
      check("run_wr_ready", 32'(bus.wr_ready), 32'd1);
      bus.wr_valid = 1'b1; bus.wr_chan = 6'd0; bus.wr_field = 2'd1; bus.wr_data = 16'h00FF;
      bus.commit = 1'b1;
      step();
      bus.wr_valid = 1'b0;
      m_sh[1][0] = 16'h00FF;
      check("run_pend_k2", 32'(bus.commit_pending), 32'd1);
      check("run_strobe_k2", 32'(bus.dp_active), 32'd0);
      check_banks("run_pend_old");
      step();
      bus.commit = 1'b0;
      check("run_pend_k3", 32'(bus.commit_pending), 32'd1);
      check("run_strobe_k3", 32'(bus.dp_active), 32'd0);
      check("run_off_old", {16'h0000, bus.offsets[15:0]}, {16'h0000, m_act[1][0]});
      step();
      m_act = m_sh;
      check("run_strobe_k4", 32'(bus.dp_active), 32'd1);
      check("run_off_new", {16'h0000, bus.offsets[15:0]}, 32'h0000_00FF);
      check("run_pend_k4", 32'(bus.commit_pending), 32'd1);
      check_banks("run_apply");
      bus.commit = 1'b1;
      step();
      bus.commit = 1'b0;
      check("run_done", 32'(bus.commit_done), 32'd1);
      check("run_pend_clear", 32'(bus.commit_pending), 32'd0);
      n_done = 0;
      for (int k = 6; k <= 13; k++) begin
         step();
         if (bus.commit_done === 1'b1) n_done++;
         check("run_strobe_after", 32'(bus.dp_active), 32'((k % SDIV) == 0));
      end
      check("run_single_done", 32'(n_done), 32'd0);
      check_banks("run_stable");
      bus.run = 1'b0;
      step();

      // result capture
      bus.dp_valid = 1'b1; bus.dp_result = 16'hFFF0;
      step();
      bus.dp_valid = 1'b0;
      check("cap_value", {16'h0000, bus.sample_out}, 32'h0000_FFF0);
      check("cap_valid", 32'(bus.sample_valid), 32'd1);
      step();
      check("cap_valid_pulse", 32'(bus.sample_valid), 32'd0);
      check("cap_hold", {16'h0000, bus.sample_out}, 32'h0000_FFF0);
      for (int i = 0; i < 4; i++) begin
         rdat = 16'($urandom);
         bus.dp_valid = 1'b1; bus.dp_result = rdat;
         step();
         bus.dp_valid = 1'b0;
         check("cap_rand", {16'h0000, bus.sample_out}, {16'h0000, rdat});
         check("cap_rand_valid", 32'(bus.sample_valid), 32'd1);
      end

      // reset while a commit is pending
      bus.run = 1'b1;
      step();
      bus.commit = 1'b1;
      step();
      bus.commit = 1'b0;
      check("rst_mid_pend_before", 32'(bus.commit_pending), 32'd1);
      #2;
      reset = 1'b0;
      bus.run = 1'b0;
      #1;
      model_clear();
      check("rst_mid_pending", 32'(bus.commit_pending), 32'd0);
      check("rst_mid_wr_ready", 32'(bus.wr_ready), 32'd0);
      check("rst_mid_wr_err", 32'(bus.wr_err), 32'd0);
      check("rst_mid_sample", {16'h0000, bus.sample_out}, 32'd0);
      check_banks("rst_mid_bank");
      @(posedge clk);
      #1;
      reset = 1'b1;
      step();
      check("post_rst_wr_ready", 32'(bus.wr_ready), 32'd1);
      check("post_rst_pending", 32'(bus.commit_pending), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/wave_bank_ctrl.md
Name: wave_bank_ctrl

Overview:
- Configuration and sequencing controller for the 64-channel oscillator summing datapath.
- Owns the per-channel parameter bank (amplitude, offset, phase word; 16 bits each). Loads it through a word-serial write port into a shadow bank.
- Commits the shadow bank atomically to the datapath-facing active bank on a sample boundary.
- Generates the periodic sample strobe that drives the datapath's activein, and captures the summed result returned with activeout.

Parameters:
- NCH, 64, number of oscillator channels (bank width = NCH*16).
- SAMPLE_DIV, 16, clk cycles per sample strobe; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- run  input  1  level; 1 = generate sample strobes.
- wr_valid  input  1  write request.
- wr_ready  output  1  write accepted when wr_valid & wr_ready.
- wr_chan  input  6  channel index 0..63.
- wr_field  input  2  0=amp, 1=offset, 2=phaseword, 3=reserved.
- wr_data  input  16  write data; amp is signed.
- commit  input  1  single-cycle pulse: request shadow→active copy.
- commit_pending  output  1  commit requested, not yet applied.
- commit_done  output  1  one-cycle pulse when the copy is applied.
- wr_err  output  1  sticky; a write to field 3 was accepted.
- amps  output  NCH*16  active amplitudes, signed; channel k at [16k+15:16k].
- offsets  output  NCH*16  active offsets, same packing.
- phasewords  output  NCH*16  active phase words, same packing.
- dp_active  output  1  datapath activein strobe.
- dp_result  input  16  datapath summed result, signed.
- dp_valid  input  1  datapath activeout.
- sample_out  output  16  last captured result, signed.
- sample_valid  output  1  one-cycle pulse, sample_out updated.

Behaviour:
- Reset (reset=0, asynchronous):
  - Shadow and active banks, tick counter, sample_out and wr_err clear to 0.
  - dp_active, commit_pending, commit_done and sample_valid clear to 0.
  - wr_ready=0 while in reset. State = IDLE.
  - Reset mid-commit discards the commit. Shadow contents are lost.
- Tick counter:
  - Counts 0..SAMPLE_DIV-1 while run=1, wrapping to 0. tick = run & (cnt==SAMPLE_DIV-1).
  - When run=0 the counter is held at 0.
  - dp_active is registered: it is 1 for exactly the cycle after each tick, otherwise 0.
- FSM states: IDLE (run=0), RUN, PENDING, APPLY.
  - IDLE→RUN when run=1.
  - RUN→IDLE when run=0.
  - RUN + commit → PENDING.
  - IDLE + commit → APPLY (no tick wait).
  - PENDING + tick → APPLY.
  - PENDING + run=0 → APPLY (a stopped datapath does not block the commit).
  - APPLY → RUN if run=1, else IDLE.
- APPLY cycle:
  - Copies the full shadow bank into the active bank at the closing edge.
  - Pulses commit_done on the following cycle.
  - When entered via tick, the new active values and dp_active become visible on the same cycle, so that strobe uses the new parameters.
- commit_pending = 1 in PENDING and APPLY.
- A commit pulse while already PENDING or APPLY is ignored; the single pending commit covers all writes.
- Writes:
  - wr_ready=1 in IDLE, RUN and PENDING; 0 in APPLY.
  - An accepted write updates shadow[wr_chan][wr_field] at the edge.
  - A write in the same cycle as commit is included in that commit.
  - field 3: write is accepted, shadow is unchanged, wr_err is set (sticky until reset).
- Active outputs change only in APPLY; writes never reach amps/offsets/phasewords directly.
- Capture: when dp_valid=1, sample_out<=dp_result and sample_valid=1 next cycle. Capture is independent of FSM state, so in-flight datapath results after run drops are still captured.
- Latency:
  - Write to shadow: 1 cycle.
  - Commit in IDLE: active outputs update 2 edges after the commit pulse (→APPLY, then copy), commit_done on the following cycle.
  - Commit in RUN: active outputs update at the cycle after the next tick.

Test Plan:
- Reset release, run=0: wr_ready=1, all outputs 0, dp_active never asserts over 100 cycles.
- SAMPLE_DIV=4, run=1 from cycle 0: dp_active pulses every 4 cycles, first pulse on cycle 4; deassert run → pulses stop, counter returns to 0.
- In IDLE, write amp ch5=0x8001, phaseword ch63=0x1234, then commit: amps[95:80]=0x8001 and phasewords[1023:1008]=0x1234 appear only after APPLY; commit_done pulses once.
- Running, SAMPLE_DIV=4: write offset ch0=0x00FF and commit at cnt=1 → commit_pending=1 for the remaining cycles; offsets[15:0]=0x00FF first appears coincident with the next dp_active; a second commit while pending is ignored (one commit_done).
- Write asserted during APPLY is held off (wr_ready=0) and accepted next cycle; field 3 write sets wr_err=1 and leaves the bank unchanged.
- dp_valid pulse with dp_result=0xFFF0 → sample_out=0xFFF0 and sample_valid=1 for one cycle. Assert reset mid-PENDING → commit_pending=0 and active bank=0 immediately.
